// File: rtl/multi_port_memory_manager.sv
// Time-slotted SRAM arbiter: each 4-cycle slot performs one video fetch followed by
// at most one round-robin-granted client read or write on the shared SRAM bus.
module multi_port_memory_manager #(
  parameter int X_BITS    = 9,
  parameter int Y_BITS    = 8,
  parameter int DATA_BITS = 8,
  parameter int NUM_PORTS = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  output logic [2:0]                     currentState,
  input  logic [X_BITS-1:0]              videoXCoord,
  input  logic [Y_BITS-1:0]              videoYCoord,
  output logic [DATA_BITS-1:0]           videoData,
  output logic                           videoDataReady,
  input  logic [NUM_PORTS*X_BITS-1:0]    memoryXCoord,
  input  logic [NUM_PORTS*Y_BITS-1:0]    memoryYCoord,
  input  logic [NUM_PORTS-1:0]           memoryReadRequest,
  input  logic [NUM_PORTS-1:0]           memoryWriteRequest,
  input  logic [NUM_PORTS*DATA_BITS-1:0] memoryWriteData,
  output logic [DATA_BITS-1:0]           memoryReadData,
  output logic [NUM_PORTS-1:0]           memoryReadComplete,
  output logic [NUM_PORTS-1:0]           memoryWriteComplete,
  output logic [X_BITS+Y_BITS-1:0]       ramAddress,
  inout  wire  [DATA_BITS-1:0]           ramData,
  output logic                           ramOutputEnable,
  output logic                           ramWriteEnable
);

  localparam int A_BITS = X_BITS + Y_BITS;
  localparam int G_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_VIDEO_READ = 3'd1;
  localparam logic [2:0] ST_MEM_WRITE  = 3'd2;
  localparam logic [2:0] ST_MEM_READ   = 3'd3;
  localparam logic [2:0] ST_NOP        = 3'd4;
  localparam logic [2:0] ST_COMPLETE   = 3'd5;

  logic [2:0]           r_state;
  logic [G_BITS-1:0]    r_last_grant;
  logic [G_BITS-1:0]    r_grant;
  logic [DATA_BITS-1:0] r_wdata;
  logic [A_BITS-1:0]    r_ram_addr;
  logic                 r_oe_n;
  logic                 r_we_n;
  logic [DATA_BITS-1:0] r_video_data;
  logic                 r_video_ready;
  logic [DATA_BITS-1:0] r_read_data;
  logic [NUM_PORTS-1:0] r_read_done;
  logic [NUM_PORTS-1:0] r_write_done;

  logic [2:0]           w_next_state;
  logic [NUM_PORTS-1:0] w_req;
  logic                 w_any_req;
  logic [G_BITS-1:0]    w_grant;
  int                   w_idx;
  logic [A_BITS-1:0]    w_next_addr;
  logic [NUM_PORTS-1:0] w_grant_onehot;

  logic [X_BITS-1:0]    w_port_x  [NUM_PORTS];
  logic [Y_BITS-1:0]    w_port_y  [NUM_PORTS];
  logic [DATA_BITS-1:0] w_port_wd [NUM_PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign w_port_x[gi]  = memoryXCoord[gi*X_BITS +: X_BITS];
      assign w_port_y[gi]  = memoryYCoord[gi*Y_BITS +: Y_BITS];
      assign w_port_wd[gi] = memoryWriteData[gi*DATA_BITS +: DATA_BITS];
    end
  endgenerate

  assign w_req          = memoryReadRequest | memoryWriteRequest;
  assign w_any_req      = |w_req;
  assign w_grant_onehot = NUM_PORTS'(1) << r_grant;

  // Scan downward so the requester nearest after lastGrant is the final assignment.
  always_comb begin
    w_grant = r_last_grant;
    w_idx   = 0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      w_idx = (int'(r_last_grant) + i) % NUM_PORTS;
      if (w_req[G_BITS'(w_idx)]) w_grant = G_BITS'(w_idx);
    end
  end

  always_comb begin
    w_next_state = ST_IDLE;
    case (r_state)
      ST_IDLE:       w_next_state = ST_VIDEO_READ;
      ST_VIDEO_READ: begin
        if (!w_any_req)                   w_next_state = ST_NOP;
        else if (memoryWriteRequest[w_grant]) w_next_state = ST_MEM_WRITE;
        else                              w_next_state = ST_MEM_READ;
      end
      ST_MEM_WRITE, ST_MEM_READ, ST_NOP: w_next_state = ST_COMPLETE;
      default:       w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_next_addr = '0;
    case (w_next_state)
      ST_VIDEO_READ:             w_next_addr = {videoYCoord, videoXCoord};
      ST_MEM_READ, ST_MEM_WRITE: w_next_addr = {w_port_y[w_grant], w_port_x[w_grant]};
      default:                   w_next_addr = '0;
    endcase
  end

  // Bus strobes and address are registered from the next state so they are
  // stable for the whole cycle of the state they belong to.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_last_grant  <= G_BITS'(NUM_PORTS - 1);
      r_grant       <= '0;
      r_wdata       <= '0;
      r_ram_addr    <= '0;
      r_oe_n        <= 1'b1;
      r_we_n        <= 1'b1;
      r_video_data  <= '0;
      r_video_ready <= 1'b0;
      r_read_data   <= '0;
      r_read_done   <= '0;
      r_write_done  <= '0;
    end else begin
      r_state       <= w_next_state;
      r_ram_addr    <= w_next_addr;
      r_oe_n        <= !((w_next_state == ST_VIDEO_READ) || (w_next_state == ST_MEM_READ));
      r_we_n        <= (w_next_state != ST_MEM_WRITE);
      r_video_ready <= (w_next_state == ST_COMPLETE);
      if (r_state == ST_VIDEO_READ) begin
        r_video_data <= ramData;
        if (w_any_req) begin
          r_grant      <= w_grant;
          r_last_grant <= w_grant;
          r_wdata      <= w_port_wd[w_grant];
        end
      end
      if (r_state == ST_MEM_READ) r_read_data <= ramData;
      r_read_done  <= (r_state == ST_MEM_READ)  ? w_grant_onehot : '0;
      r_write_done <= (r_state == ST_MEM_WRITE) ? w_grant_onehot : '0;
    end
  end

  assign ramData             = r_we_n ? {DATA_BITS{1'bz}} : r_wdata;
  assign currentState        = r_state;
  assign ramAddress          = r_ram_addr;
  assign ramOutputEnable     = r_oe_n;
  assign ramWriteEnable      = r_we_n;
  assign videoData           = r_video_data;
  assign videoDataReady      = r_video_ready;
  assign memoryReadData      = r_read_data;
  assign memoryReadComplete  = r_read_done;
  assign memoryWriteComplete = r_write_done;

endmodule

// File: tb/tb_multi_port_memory_manager.sv
// Directed bench: 2-port manager against an SRAM model, plus a 4-port instance
// exercising round-robin wrap-around.
module tb_multi_port_memory_manager;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // 2-port DUT
  logic [2:0]  currentState;
  logic [8:0]  videoXCoord;
  logic [7:0]  videoYCoord;
  logic [7:0]  videoData;
  logic        videoDataReady;
  logic [17:0] memoryXCoord;
  logic [15:0] memoryYCoord;
  logic [1:0]  memoryReadRequest;
  logic [1:0]  memoryWriteRequest;
  logic [15:0] memoryWriteData;
  logic [7:0]  memoryReadData;
  logic [1:0]  memoryReadComplete;
  logic [1:0]  memoryWriteComplete;
  logic [16:0] ramAddress;
  wire  [7:0]  ramData;
  logic        ramOutputEnable;
  logic        ramWriteEnable;

  // 4-port DUT
  logic [2:0]  state4;
  logic [7:0]  vdata4;
  logic        vready4;
  logic [35:0] x4;
  logic [31:0] y4;
  logic [3:0]  rd4;
  logic [3:0]  wr4;
  logic [31:0] wd4;
  logic [7:0]  rdata4;
  logic [3:0]  rdc4;
  logic [3:0]  wrc4;
  logic [16:0] addr4;
  wire  [7:0]  ramData4;
  logic        oe4;
  logic        we4;

  logic [7:0] mem [0:131071];

  int n_checks = 0;
  int n_pass   = 0;

  multi_port_memory_manager u_dut (
    .clock(clock), .reset(reset), .currentState(currentState),
    .videoXCoord(videoXCoord), .videoYCoord(videoYCoord),
    .videoData(videoData), .videoDataReady(videoDataReady),
    .memoryXCoord(memoryXCoord), .memoryYCoord(memoryYCoord),
    .memoryReadRequest(memoryReadRequest), .memoryWriteRequest(memoryWriteRequest),
    .memoryWriteData(memoryWriteData), .memoryReadData(memoryReadData),
    .memoryReadComplete(memoryReadComplete), .memoryWriteComplete(memoryWriteComplete),
    .ramAddress(ramAddress), .ramData(ramData),
    .ramOutputEnable(ramOutputEnable), .ramWriteEnable(ramWriteEnable)
  );

  multi_port_memory_manager #(.NUM_PORTS(4)) u_dut4 (
    .clock(clock), .reset(reset), .currentState(state4),
    .videoXCoord(videoXCoord), .videoYCoord(videoYCoord),
    .videoData(vdata4), .videoDataReady(vready4),
    .memoryXCoord(x4), .memoryYCoord(y4),
    .memoryReadRequest(rd4), .memoryWriteRequest(wr4),
    .memoryWriteData(wd4), .memoryReadData(rdata4),
    .memoryReadComplete(rdc4), .memoryWriteComplete(wrc4),
    .ramAddress(addr4), .ramData(ramData4),
    .ramOutputEnable(oe4), .ramWriteEnable(we4)
  );

  // SRAM model for the 2-port instance
  assign ramData = (!ramOutputEnable && ramWriteEnable) ? mem[ramAddress] : 8'hzz;
  always @(posedge clock) if (!ramWriteEnable) mem[ramAddress] <= ramData;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_for(input bit four, input logic [2:0] s, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 24 && !hit; i++) begin
      step();
      if ((four ? state4 : currentState) == s) hit = 1'b1;
    end
    check_val(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    videoXCoord = 9'd5; videoYCoord = 8'd3;
    memoryXCoord = '0; memoryYCoord = '0;
    memoryReadRequest = '0; memoryWriteRequest = '0; memoryWriteData = '0;
    x4 = '0; y4 = '0; rd4 = 4'b1010; wr4 = '0; wd4 = '0;
    mem[1541] = 8'h5A;   // {3,5}
    mem[1034] = 8'h3C;   // {2,10}

    // reset state
    repeat (3) step();
    check_val("rst_state", 32'(currentState), 32'd0);
    check_val("rst_addr",  32'(ramAddress), 32'd0);
    check_val("rst_oe",    32'(ramOutputEnable), 32'd1);
    check_val("rst_we",    32'(ramWriteEnable), 32'd1);
    check_val("rst_vdata", 32'(videoData), 32'd0);
    check_val("rst_rdata", 32'(memoryReadData), 32'd0);
    check_val("rst_vrdy",  32'(videoDataReady), 32'd0);
    check_val("rst_cmp",   32'({memoryReadComplete, memoryWriteComplete}), 32'd0);
    $display("reset: state=%0d addr=%0d", currentState, ramAddress);
    reset = 1'b1;

    // idle slot: NOP with video fetch
    wait_for(1'b0, 3'd1, "idle_reach_vr");
    check_val("idle_vr_addr", 32'(ramAddress), 32'd1541);
    check_val("idle_vr_oe",   32'(ramOutputEnable), 32'd0);
    check_val("idle_vr_we",   32'(ramWriteEnable), 32'd1);
    step();
    check_val("idle_nop",     32'(currentState), 32'd4);
    check_val("idle_vdata",   32'(videoData), 32'h5A);
    check_val("idle_nop_oe",  32'(ramOutputEnable), 32'd1);
    check_val("idle_nop_adr", 32'(ramAddress), 32'd0);
    step();
    check_val("idle_cpl",     32'(currentState), 32'd5);
    check_val("idle_vrdy",    32'(videoDataReady), 32'd1);
    check_val("idle_nocmp",   32'({memoryReadComplete, memoryWriteComplete}), 32'd0);
    step();
    check_val("idle_vrdy_lo", 32'(videoDataReady), 32'd0);
    step();
    check_val("idle_period",  32'(currentState), 32'd1);
    $display("idle: videoData=0x%0h", videoData);

    // single write, port 0, 0xA5 to (319,239)
    wait_for(1'b0, 3'd0, "wr_reach_idle");
    memoryWriteRequest = 2'b01;
    memoryXCoord = {9'd0, 9'd319}; memoryYCoord = {8'd0, 8'd239};
    memoryWriteData = {8'h00, 8'hA5};
    step(); step();
    check_val("wr_state", 32'(currentState), 32'd2);
    check_val("wr_we",    32'(ramWriteEnable), 32'd0);
    check_val("wr_oe",    32'(ramOutputEnable), 32'd1);
    check_val("wr_addr",  32'(ramAddress), 32'd122687);
    check_val("wr_data",  32'(ramData), 32'hA5);
    memoryWriteData = {8'h00, 8'h11}; memoryXCoord = '0;
    #1;
    check_val("wr_latched", 32'(ramData), 32'hA5);
    check_val("wr_lat_adr", 32'(ramAddress), 32'd122687);
    step();
    check_val("wr_wcmp",  32'(memoryWriteComplete), 32'd1);
    check_val("wr_rcmp",  32'(memoryReadComplete), 32'd0);
    check_val("wr_we_hi", 32'(ramWriteEnable), 32'd1);
    check_val("wr_mem",   32'(mem[122687]), 32'hA5);
    $display("write: port0 addr=%0d data=0x%0h", 122687, mem[122687]);
    step();
    memoryWriteRequest = 2'b00;
    step(); step();
    check_val("wr_no_reserv", 32'(currentState), 32'd4);

    // read, port 1, (10,2)
    wait_for(1'b0, 3'd0, "rd_reach_idle");
    memoryReadRequest = 2'b10;
    memoryXCoord = {9'd10, 9'd0}; memoryYCoord = {8'd2, 8'd0};
    step(); step();
    check_val("rd_state", 32'(currentState), 32'd3);
    check_val("rd_oe",    32'(ramOutputEnable), 32'd0);
    check_val("rd_we",    32'(ramWriteEnable), 32'd1);
    check_val("rd_addr",  32'(ramAddress), 32'd1034);
    step();
    check_val("rd_data",  32'(memoryReadData), 32'h3C);
    check_val("rd_rcmp",  32'(memoryReadComplete), 32'd2);
    check_val("rd_wcmp",  32'(memoryWriteComplete), 32'd0);
    $display("read: port1 data=0x%0h", memoryReadData);
    memoryReadRequest = 2'b00;

    // read+write on port 0 -> write wins
    wait_for(1'b0, 3'd0, "rw_reach_idle");
    memoryReadRequest = 2'b01; memoryWriteRequest = 2'b01;
    memoryXCoord = {9'd0, 9'd1}; memoryYCoord = {8'd0, 8'd1};
    memoryWriteData = {8'h00, 8'h77};
    step(); step();
    check_val("rw_state", 32'(currentState), 32'd2);
    step();
    check_val("rw_wcmp",  32'(memoryWriteComplete), 32'd1);
    check_val("rw_rcmp",  32'(memoryReadComplete), 32'd0);
    check_val("rw_rdhold", 32'(memoryReadData), 32'h3C);
    check_val("rw_mem",   32'(mem[513]), 32'h77);
    $display("rw: port0 wrote 0x%0h", mem[513]);
    memoryReadRequest = 2'b00; memoryWriteRequest = 2'b00;

    // contention: lastGrant is 0, so grants go 1,0,1,0
    wait_for(1'b0, 3'd0, "ct_reach_idle");
    memoryReadRequest = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_for(1'b0, 3'd5, "ct_reach_cpl");
      check_val("ct_grant", 32'(memoryReadComplete), (k % 2 == 0) ? 32'd2 : 32'd1);
      check_val("ct_vrdy",  32'(videoDataReady), 32'd1);
      $display("contention slot %0d: readComplete=%b", k, memoryReadComplete);
    end
    memoryReadRequest = 2'b00;

    // 4 ports, ports 1 and 3 requesting from reset: grants 1,3,1
    reset = 1'b0;
    step(); step();
    check_val("p4_rst_state", 32'(state4), 32'd0);
    check_val("p4_rst_cmp",   32'(rdc4), 32'd0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_for(1'b1, 3'd5, "p4_reach_cpl");
      check_val("p4_grant", 32'(rdc4), (k == 1) ? 32'd8 : 32'd2);
      $display("4-port slot %0d: readComplete=%b", k, rdc4);
    end

    // reset during MEM_WRITE
    wait_for(1'b0, 3'd0, "rs_reach_idle");
    memoryWriteRequest = 2'b01;
    memoryXCoord = {9'd0, 9'd7}; memoryYCoord = {8'd0, 8'd7};
    memoryWriteData = {8'h00, 8'h42};
    step(); step();
    check_val("rs_state_wr", 32'(currentState), 32'd2);
    check_val("rs_we_lo",    32'(ramWriteEnable), 32'd0);
    reset = 1'b0;
    step();
    check_val("rs_we_hi",  32'(ramWriteEnable), 32'd1);
    check_val("rs_state",  32'(currentState), 32'd0);
    check_val("rs_nocmp",  32'(memoryWriteComplete), 32'd0);
    check_val("rs_addr",   32'(ramAddress), 32'd0);
    step();
    check_val("rs_nocmp2", 32'(memoryWriteComplete), 32'd0);
    reset = 1'b1;
    wait_for(1'b0, 3'd5, "rs_reach_cpl");
    check_val("rs_served", 32'(memoryWriteComplete), 32'd1);
    check_val("rs_mem",    32'(mem[3591]), 32'h42);
    $display("reset-mid-write: served after release, writeComplete=%b", memoryWriteComplete);
    memoryWriteRequest = 2'b00;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
